// File: rtl/traffic_light.sv
// Signal-head lamp driver with an embedded clock divider for controller pacing.
// Build option TRAFFIC_LIGHT_BLINK_EN: state 2'b11 flashes yellow instead of steady red.
module traffic_light #(
   parameter int DIV_N      = 25000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] state,
   input  logic       lamp_test,
   output logic       green,
   output logic       yellow,
   output logic       red,
   output logic       clk_div,
   output logic       tick
);

   localparam int HALF = DIV_N / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] TERM = CW'(HALF - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic          POL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [CW-1:0] cnt_r;
   logic          clk_div_r;
   logic          tick_r;
   logic [2:0]    lamp_s;   // logical {green, yellow, red}, 1 = lit
   logic [2:0]    pin_r;    // pin-level {green, yellow, red}

   // Half-period counter, divided clock and rising-edge tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= {CW{1'b0}};
         clk_div_r <= 1'b0;
         tick_r    <= 1'b0;
      end else if (cnt_r == TERM) begin
         cnt_r     <= {CW{1'b0}};
         clk_div_r <= ~clk_div_r;
         tick_r    <= ~clk_div_r;
      end else begin
         cnt_r     <= cnt_r + ONE;
         clk_div_r <= clk_div_r;
         tick_r    <= 1'b0;
      end
   end

   // Decode requested light state into logical lamp values
   always_comb begin
      lamp_s = 3'b001;
      if (lamp_test) begin
         lamp_s = 3'b111;
      end else begin
         case (state)
            2'b00:   lamp_s = 3'b001;
            2'b01:   lamp_s = 3'b010;
            2'b10:   lamp_s = 3'b100;
`ifdef TRAFFIC_LIGHT_BLINK_EN
            2'b11:   lamp_s = {1'b0, clk_div_r, 1'b0};
`else
            2'b11:   lamp_s = 3'b001;
`endif
            default: lamp_s = 3'b001;
         endcase
      end
   end

   // Register lamp pins with board polarity applied; reset shows red
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pin_r <= {POL, POL, ~POL};
      end else begin
         pin_r <= lamp_s ^ {3{POL}};
      end
   end

   assign green   = pin_r[2];
   assign yellow  = pin_r[1];
   assign red     = pin_r[0];
   assign clk_div = clk_div_r;
   assign tick    = tick_r;

endmodule

// File: tb/tb_traffic_light.sv
// Randomized self-checking bench for traffic_light against an edge-count reference model.
// Honours TRAFFIC_LIGHT_BLINK_EN the same way the design build does.
module tb_traffic_light;

   localparam int DIV_N = 4;
   localparam int HALF  = DIV_N / 2;
   localparam int AL    = 1;

   logic       clk;
   logic       rst_n;
   logic [1:0] state;
   logic       lamp_test;
   logic       green, yellow, red, clk_div, tick;

   int n_checks;
   int n_errors;
   int e;   // rising edges seen since reset release

   traffic_light #(.DIV_N(DIV_N), .ACTIVE_LOW(AL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .lamp_test (lamp_test),
      .green     (green),
      .yellow    (yellow),
      .red       (red),
      .clk_div   (clk_div),
      .tick      (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
      end
   endtask

   function automatic logic div_at(input int edges);
      return ((edges / HALF) % 2) == 1;
   endfunction

   // Expected pin triple {green,yellow,red} after edge n given inputs sampled at that edge
   function automatic logic [2:0] lamps_at(input int n, input logic [1:0] st, input logic lt);
      logic [2:0] lg;
      if (n == 0)       lg = 3'b001;
      else if (lt)      lg = 3'b111;
      else if (st == 2'd0) lg = 3'b001;
      else if (st == 2'd1) lg = 3'b010;
      else if (st == 2'd2) lg = 3'b100;
      else begin
`ifdef TRAFFIC_LIGHT_BLINK_EN
         lg = {1'b0, div_at(n - 1), 1'b0};
`else
         lg = 3'b001;
`endif
      end
      return lg ^ {3{AL[0]}};
   endfunction

   task automatic step(input logic [1:0] st, input logic lt);
      state     = st;
      lamp_test = lt;
      @(posedge clk);
      e++;
      #1;
      check("lamps",   {5'd0, green, yellow, red}, {5'd0, lamps_at(e, st, lt)});
      check("clk_div", {7'd0, clk_div}, {7'd0, div_at(e)});
      check("tick",    {7'd0, tick}, {7'd0, ((e % DIV_N) == HALF)});
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      e         = 0;
      rst_n     = 1'b0;
      state     = 2'b10;
      lamp_test = 1'b0;
      #12;
      check("rst_lamps", {5'd0, green, yellow, red}, 8'h06);
      check("rst_div",   {7'd0, clk_div}, 8'h00);
      check("rst_tick",  {7'd0, tick}, 8'h00);
      #1 rst_n = 1'b1;

      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 3; k++) step(2'(2 - s), 1'b0);
      end
      for (int k = 0; k < 8; k++) step(2'b11, 1'b0);
      step(2'b10, 1'b0);
      step(2'b10, 1'b1);
      step(2'b10, 1'b1);
      step(2'b10, 1'b0);
      step(2'b10, 1'b0);

      for (int k = 0; k < 200; k++) step(2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));

      // Drive to green with clk_div high, then reset between edges
      for (int k = 0; k < DIV_N && !(div_at(e) && e > 0); k++) step(2'b10, 1'b0);
      step(2'b10, 1'b0);
      check("pre_rst_green", {5'd0, green, yellow, red}, 8'h03);
      for (int k = 0; k < DIV_N && !div_at(e); k++) step(2'b10, 1'b0);
      check("pre_rst_div", {7'd0, clk_div}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_lamps", {5'd0, green, yellow, red}, 8'h06);
      check("mid_rst_div",   {7'd0, clk_div}, 8'h00);
      check("mid_rst_tick",  {7'd0, tick}, 8'h00);
      #2 rst_n = 1'b1;
      e = 0;

      for (int k = 0; k < 150; k++) step(2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
